// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use interlock, taken-branch flush,
// variable-latency data-memory freeze with timeout watchdog and saturating performance counters.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_instr_rs,
    input  logic [4:0]       if_id_instr_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_write_reg_addr,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             mem_waiting,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX   = WCNT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic [WCNT_W-1:0] wait_cnt;

    logic freeze;
    logic load_use;
    logic do_flush;
    logic do_load_stall;

    assign freeze   = dmem_req && !dmem_ready;
    assign load_use = id_ex_mem_read && (id_ex_write_reg_addr != 5'd0) &&
                      ((id_ex_write_reg_addr == if_id_instr_rs) ||
                       (if_id_uses_rt && (id_ex_write_reg_addr == if_id_instr_rt)));

    // A freeze holds EX and ID unchanged, so branch and load-use are simply re-evaluated later.
    assign do_flush      = !freeze && branch_taken;
    assign do_load_stall = !freeze && !branch_taken && load_use;

    assign mem_waiting = (state == WAIT);

    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        next_state = state;
        case (state)
            RUN:     if (dmem_req && !dmem_ready) next_state = WAIT;
            WAIT:    if (dmem_ready)              next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (do_flush) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pc_write     = 1'b1;
        end else if (do_load_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == WAIT) begin
                if (state == RUN)
                    wait_cnt <= WCNT_W'(1);
                else if (wait_cnt != WCNT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            // Error is sticky; the freeze itself is unaffected by it.
            if ((state == WAIT) && !dmem_ready && (wait_cnt >= WCNT_LIMIT))
                mem_timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((freeze || do_load_stall) && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (do_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed test-plan cases plus randomized
// stimulus compared every cycle against a behavioural model of the stall/flush rules.
module tb_hazard_stall_unit;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control vector order: pc, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble
    localparam logic [6:0] C_RESET  = 7'b0000101;
    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LOADU  = 7'b0001110;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       if_id_instr_rs = '0;
    logic [4:0]       if_id_instr_rt = '0;
    logic             if_id_uses_rt = 1'b0;
    logic             id_ex_mem_read = 1'b0;
    logic [4:0]       id_ex_write_reg_addr = '0;
    logic             branch_taken = 1'b0;
    logic             dmem_req = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             pc_write, if_id_write, if_id_flush, id_ex_write;
    logic             id_ex_bubble, ex_mem_write, mem_wb_bubble;
    logic             mem_waiting, mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_waiting;
    int m_wait_len;
    bit m_err;
    int m_stalls;
    int m_flushes;

    hazard_stall_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .if_id_instr_rs       (if_id_instr_rs),
        .if_id_instr_rt       (if_id_instr_rt),
        .if_id_uses_rt        (if_id_uses_rt),
        .id_ex_mem_read       (id_ex_mem_read),
        .id_ex_write_reg_addr (id_ex_write_reg_addr),
        .branch_taken         (branch_taken),
        .dmem_req             (dmem_req),
        .dmem_ready           (dmem_ready),
        .pc_write             (pc_write),
        .if_id_write          (if_id_write),
        .if_id_flush          (if_id_flush),
        .id_ex_write          (id_ex_write),
        .id_ex_bubble         (id_ex_bubble),
        .ex_mem_write         (ex_mem_write),
        .mem_wb_bubble        (mem_wb_bubble),
        .mem_waiting          (mem_waiting),
        .mem_timeout_err      (mem_timeout_err),
        .stall_cycles         (stall_cycles),
        .flush_count          (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write, mem_wb_bubble};
    endfunction

    function automatic bit model_load_use();
        logic [4:0] d;
        d = id_ex_write_reg_addr;
        return id_ex_mem_read && d != 0 && (d == if_id_instr_rs || (if_id_uses_rt && d == if_id_instr_rt));
    endfunction

    function automatic logic [6:0] model_ctrl();
        if (dmem_req && !dmem_ready) return C_FREEZE;
        if (branch_taken)            return C_BRANCH;
        if (model_load_use())        return C_LOADU;
        return C_NORMAL;
    endfunction

    task automatic set_idle();
        dmem_req = 0; dmem_ready = 0; branch_taken = 0; id_ex_mem_read = 0;
        id_ex_write_reg_addr = 0; if_id_instr_rs = 0; if_id_instr_rt = 0; if_id_uses_rt = 0;
    endtask

    task automatic model_clear();
        m_waiting = 0; m_wait_len = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, 32'(ctrl_vec()), 32'(C_RESET));
        check({tag, "_waiting"}, 32'(mem_waiting), 32'd0);
        check({tag, "_err"}, 32'(mem_timeout_err), 32'd0);
        check({tag, "_stalls"}, 32'(stall_cycles), 32'd0);
        check({tag, "_flushes"}, 32'(flush_count), 32'd0);
    endtask

    // Synchronous-looking entry, but values are checked before any clock edge occurs.
    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1;
        #1;
        check_reset_values("reset");
        model_clear();
        @(negedge clk);
        reset = 0;
    endtask

    // Drive one cycle of inputs, compare all outputs to the model, then advance the model.
    task automatic step(input bit req, input bit rdy, input bit br, input bit mr,
                        input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt, input bit ur);
        bit fr, lu;
        @(negedge clk);
        dmem_req = req; dmem_ready = rdy; branch_taken = br; id_ex_mem_read = mr;
        id_ex_write_reg_addr = wa; if_id_instr_rs = rs; if_id_instr_rt = rt; if_id_uses_rt = ur;
        #1;
        // Error is visible once a stall has lasted MEM_TIMEOUT wait cycles.
        if (m_waiting && m_wait_len >= MEM_TIMEOUT) m_err = 1;
        check("ctrl", 32'(ctrl_vec()), 32'(model_ctrl()));
        check("waiting", 32'(mem_waiting), 32'(m_waiting));
        check("timeout_err", 32'(mem_timeout_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        check("flush_count", 32'(flush_count), 32'(m_flushes));
        @(posedge clk);
        fr = req && !rdy;
        lu = model_load_use();
        if (fr)      m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls + 1  : CNT_MAX;
        else if (br) m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
        else if (lu) m_stalls  = (m_stalls  < CNT_MAX) ? m_stalls + 1  : CNT_MAX;
        if (m_waiting) begin
            if (rdy) begin m_waiting = 0; m_wait_len = 0; end
            else m_wait_len++;
        end else if (fr) begin
            m_waiting = 1; m_wait_len = 1;
        end
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        set_idle();
        reset = 1;
        #2;
        check_reset_values("por");
        do_reset();

        // Load-use through rs, then destination $0 must not stall
        step(0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0);
        idle_step();
        #1 check("lu_rs_stalls", 32'(stall_cycles), 32'd1);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
        #1 check("lu_zero_stalls", 32'(stall_cycles), 32'd1);

        // rt match only counts when the ID instruction reads rt
        step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0);
        step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1);
        #1 check("lu_rt_stalls", 32'(stall_cycles), 32'd2);

        // Memory wait: three frozen cycles, ready on the fourth
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle_step();
        #1 check("wait_stalls", 32'(stall_cycles), 32'd3);
        check("wait_done", 32'(mem_waiting), 32'd0);

        // Branch beats load-use
        do_reset();
        step(0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0);
        #1 check("br_lu_stalls", 32'(stall_cycles), 32'd0);
        check("br_lu_flushes", 32'(flush_count), 32'd1);

        // Branch held during a freeze is only taken once memory is ready
        do_reset();
        repeat (2) step(1, 0, 1, 0, 0, 0, 0, 0);
        #1 check("br_frozen_flushes", 32'(flush_count), 32'd0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        #1 check("br_after_ready_flushes", 32'(flush_count), 32'd1);

        // Timeout, sticky, then asynchronous reset mid-wait
        do_reset();
        repeat (6) step(1, 0, 0, 0, 0, 0, 0, 0);
        #1 check("timeout_set", 32'(mem_timeout_err), 32'd1);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle_step();
        #1 check("timeout_sticky", 32'(mem_timeout_err), 32'd1);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        reset = 1;
        #1;
        check_reset_values("async_reset");
        model_clear();
        @(negedge clk);
        set_idle();
        reset = 0;

        // Saturation of the stall counter
        repeat (20) step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        #1 check("stall_saturate", 32'(stall_cycles), 32'(CNT_MAX));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bit req, rdy;
            req = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            step(req, rdy, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
